// File: rtl/svfloat_add_arbiter.sv
// Round-robin arbiter sharing one svfloat_add between NUM_REQ valid/ready requesters,
// with an ID pipe that follows the adder and a credit-protected result FIFO.
// Latency: issue -> res_valid is LATENCY + 1 cycles minimum.
// Backpressure: res_ready low holds results; credits stop issue once FIFO_DEPTH ops are outstanding.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   req_valid/req_ready    per-requester handshake (req_ready is the one-hot grant)
//   req_sub                per-requester subtract select (flips the rhs sign)
//   req_lhs/req_rhs        per-requester operands, packed by requester index
//   add_lhs/add_rhs        operands driven into the shared svfloat_add
//   add_res                result returned by svfloat_add, LATENCY cycles later
//   res_valid/res_ready    result handshake at the FIFO head
//   res_id/res_data        requester index and result at the FIFO head

package svfloat;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } float32;
endpackage

module svfloat_add_arbiter #(
  parameter type float = svfloat::float32,
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 0,
  parameter int FIFO_DEPTH = 4,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ-1:0]                   req_sub,
  input  logic [NUM_REQ-1:0][$bits(float)-1:0] req_lhs,
  input  logic [NUM_REQ-1:0][$bits(float)-1:0] req_rhs,
  output float                                 add_lhs,
  output float                                 add_rhs,
  input  float                                 add_res,
  output logic                                 res_valid,
  input  logic                                 res_ready,
  output logic [ID_W-1:0]                      res_id,
  output float                                 res_data
);

  localparam int FW = $bits(float);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant;
  logic            found;
  logic            issue;
  logic [CW-1:0]   credits;
  logic            pop;
  int              idx;

  // First valid requester at or above rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!found && req_valid[ID_W'(idx)]) begin
        found = 1'b1;
        grant = ID_W'(idx);
      end
    end
  end

  // Credits already cover every in-flight op, so a grant can never overflow the FIFO.
  assign issue = (credits != '0) && (|req_valid);

  always_comb begin
    req_ready = '0;
    if (issue) begin
      req_ready[grant] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Adder drive: subtraction is an addition with the rhs sign bit flipped
  // ---------------------------------------------------------------------------
  logic [FW-1:0] lhs_bits;
  logic [FW-1:0] rhs_bits;

  always_comb begin
    lhs_bits = '0;
    rhs_bits = '0;
    if (issue) begin
      lhs_bits         = req_lhs[grant];
      rhs_bits         = req_rhs[grant];
      rhs_bits[FW-1]   = req_rhs[grant][FW-1] ^ req_sub[grant];
    end
  end

  assign add_lhs = float'(lhs_bits);
  assign add_rhs = float'(rhs_bits);

  // ---------------------------------------------------------------------------
  // ID pipe: mirrors the adder stages so the result and its owner arrive together
  // ---------------------------------------------------------------------------
  logic            wr_en;
  logic [ID_W-1:0] wr_id;

  generate
    if (LATENCY == 0) begin : g_no_pipe
      assign wr_en = issue;
      assign wr_id = grant;
    end else begin : g_pipe
      logic [LATENCY-1:0]           pipe_vld;
      logic [LATENCY-1:0][ID_W-1:0] pipe_id;

      // No stall: the adder itself cannot stall, so neither can its shadow.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pipe_vld <= '0;
          pipe_id  <= '0;
        end else begin
          pipe_vld[0] <= issue;
          pipe_id[0]  <= grant;
          for (int s = 1; s < LATENCY; s++) begin
            pipe_vld[s] <= pipe_vld[s-1];
            pipe_id[s]  <= pipe_id[s-1];
          end
        end
      end

      assign wr_en = pipe_vld[LATENCY-1];
      assign wr_id = pipe_id[LATENCY-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Credits: one per FIFO slot; taken at issue, returned at pop
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits <= CW'(FIFO_DEPTH);
    end else if (issue && !pop) begin
      credits <= credits - 1'b1;
    end else if (pop && !issue) begin
      credits <= credits + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Result FIFO: head is read straight from storage flops, so a write is
  // visible on res_* the following cycle
  // ---------------------------------------------------------------------------
  logic [FW-1:0]   mem_dat [FIFO_DEPTH];
  logic [ID_W-1:0] mem_id  [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  assign pop = res_valid && res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_dat[i] <= '0;
        mem_id[i]  <= '0;
      end
    end else begin
      if (wr_en) begin
        mem_dat[wr_ptr] <= add_res;
        mem_id[wr_ptr]  <= wr_id;
        wr_ptr          <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      if (wr_en && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !wr_en) begin
        count <= count - 1'b1;
      end
    end
  end

  assign res_valid = (count != '0);
  assign res_id    = mem_id[rd_ptr];
  assign res_data  = float'(mem_dat[rd_ptr]);

  // A write into a full FIFO would mean the credit accounting is broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(wr_en && (count == CW'(FIFO_DEPTH)) && !pop));

endmodule

// File: tb/tb_svfloat_add_arbiter.sv
// Bench for svfloat_add_arbiter with NUM_REQ=4, LATENCY=2, FIFO_DEPTH=4.
// The attached adder is a small integer-valued float32 model (NaN in -> NaN out).
module tb_svfloat_add_arbiter;

  localparam int N     = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int IDW   = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req_valid;
  logic [N-1:0]        req_ready;
  logic [N-1:0]        req_sub;
  logic [N-1:0][31:0]  req_lhs;
  logic [N-1:0][31:0]  req_rhs;
  logic [31:0]         add_lhs;
  logic [31:0]         add_rhs;
  logic [31:0]         add_res;
  logic                res_valid;
  logic                res_ready;
  logic [IDW-1:0]      res_id;
  logic [31:0]         res_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  svfloat_add_arbiter #(.NUM_REQ(N), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
    .req_lhs(req_lhs), .req_rhs(req_rhs),
    .add_lhs(add_lhs), .add_rhs(add_rhs), .add_res(add_res),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_data(res_data)
  );

  // ---------------- float helpers (exact for integers below 2^24) ----------------
  function automatic logic [31:0] i2f(input int n);
    logic        s;
    logic [31:0] a;
    logic [31:0] m;
    int          p;
    s = (n < 0);
    a = s ? 32'(-n) : 32'(n);
    if (a == 0) return 32'h0;
    p = 0;
    for (int k = 0; k < 24; k++) if (a[k]) p = k;
    m = a << (23 - p);
    return {s, 8'(127 + p), m[22:0]};
  endfunction

  function automatic int f2i(input logic [31:0] f);
    int          p;
    logic [31:0] m;
    int          a;
    if (f[30:23] == 8'h00) return 0;
    p = int'(f[30:23]) - 127;
    m = {8'h00, 1'b1, f[22:0]};
    a = int'(m >> (23 - p));
    return f[31] ? -a : a;
  endfunction

  function automatic bit is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 23'h0);
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    if (is_nan(a) || is_nan(b)) return 32'h7FC00000;
    return i2f(f2i(a) + f2i(b));
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // ---------------- adder model: LAT register stages on the operands ----------------
  logic [31:0] l_d1, l_d2, r_d1, r_d2;
  always @(posedge clk) begin
    l_d1 <= add_lhs; r_d1 <= add_rhs;
    l_d2 <= l_d1;    r_d2 <= r_d1;
  end
  always_comb add_res = fadd(l_d2, r_d2);

  // ---------------- reference model: round robin + credits + in-order scoreboard ----------------
  logic [IDW-1:0] q_id[$];
  logic [31:0]    q_dat[$];
  int             q_cyc[$];
  int             m_ptr = 0;
  int             outstanding = 0;
  int             cyc = 0;
  logic [N-1:0]   m_rdy;
  bit             m_found;
  int             m_g;
  logic [31:0]    m_rhs;

  always @(negedge clk) begin
    cyc++;
    if (rst === 1'b1) begin
      q_id.delete(); q_dat.delete(); q_cyc.delete();
      m_ptr = 0;
      outstanding = 0;
    end else begin
      m_rdy = '0;
      m_found = 0;
      if (outstanding < DEPTH) begin
        for (int i = 0; i < N; i++) begin
          m_g = (m_ptr + i) % N;
          if (!m_found && req_valid[m_g]) begin
            m_found = 1;
            m_rdy[m_g] = 1'b1;
          end
        end
      end
      checks++;
      if (req_ready !== m_rdy) begin
        errors++;
        $display("FAIL grant cyc=%0d: req_ready=%b required %b", cyc, req_ready, m_rdy);
      end
      if ((req_valid & req_ready) != '0) begin
        m_g   = onehot_idx(req_valid & req_ready);
        m_rhs = req_rhs[m_g] ^ {req_sub[m_g], 31'h0};
        checks++;
        if (add_lhs !== req_lhs[m_g] || add_rhs !== m_rhs) begin
          errors++;
          $display("FAIL adder_drive cyc=%0d: lhs=%h rhs=%h required %h %h",
                   cyc, add_lhs, add_rhs, req_lhs[m_g], m_rhs);
        end
        q_id.push_back(IDW'(m_g));
        q_dat.push_back(fadd(req_lhs[m_g], m_rhs));
        q_cyc.push_back(cyc);
        m_ptr = (m_g + 1) % N;
        outstanding++;
      end
      if (res_valid === 1'b1) begin
        checks++;
        if (q_id.size() == 0) begin
          errors++;
          $display("FAIL result cyc=%0d: res_valid=1 id=%0d data=%h required no result", cyc, res_id, res_data);
        end else if (res_id !== q_id[0] || res_data !== q_dat[0] || (cyc - q_cyc[0]) < LAT + 1) begin
          errors++;
          $display("FAIL result cyc=%0d: id=%0d data=%h after %0d cycles required id=%0d data=%h after >=%0d",
                   cyc, res_id, res_data, cyc - q_cyc[0], q_id[0], q_dat[0], LAT + 1);
        end
        if (res_ready === 1'b1 && q_id.size() != 0) begin
          void'(q_id.pop_front()); void'(q_dat.pop_front()); void'(q_cyc.pop_front());
          outstanding--;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1; req_valid = '0; res_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic rand_operands();
    for (int i = 0; i < N; i++) begin
      req_lhs[i] = i2f(int'($urandom_range(0, 2000)) - 1000);
      req_rhs[i] = i2f(int'($urandom_range(0, 2000)) - 1000);
      req_sub[i] = 1'($urandom_range(0, 1));
    end
  endtask

  // One isolated op on requester idx; reports what was seen at issue and at the result.
  task automatic single_op(input int idx, input logic [31:0] l, input logic [31:0] r, input logic s,
                           output logic [N-1:0] rdy_seen, output logic [31:0] lhs_seen,
                           output logic [31:0] rhs_seen, output int lat,
                           output logic [IDW-1:0] id, output logic [31:0] dat);
    tick();
    req_valid = '0; req_valid[idx] = 1'b1;
    req_lhs[idx] = l; req_rhs[idx] = r; req_sub[idx] = s; res_ready = 1'b0;
    @(negedge clk);
    rdy_seen = req_ready; lhs_seen = add_lhs; rhs_seen = add_rhs;
    tick();
    req_valid = '0;
    lat = -1; id = '0; dat = '0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        lat = c; id = res_id; dat = res_data;
      end
    end
    tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_sub = '0; req_lhs = '0; req_rhs = '0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b required 0", res_valid); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b required 0", req_ready); end
    checks++; if (res_id !== '0) begin errors++; $display("FAIL reset_res_id: got %0d required 0", res_id); end
    checks++; if (res_data !== 32'h0) begin errors++; $display("FAIL reset_res_data: got %h required 0", res_data); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL release_res_valid: got %b required 0", res_valid); end
  endtask

  task automatic test_add_basic();
    logic [N-1:0] rdy; logic [31:0] l, r, d; logic [IDW-1:0] id; int lat;
    single_op(0, 32'h3F800000, 32'h40000000, 1'b0, rdy, l, r, lat, id, d);
    checks++; if (rdy !== 4'b0001) begin errors++; $display("FAIL add_grant: got %b required 0001", rdy); end
    checks++; if (l !== 32'h3F800000 || r !== 32'h40000000) begin errors++; $display("FAIL add_drive: got %h %h required 3f800000 40000000", l, r); end
    checks++; if (lat != LAT + 1) begin errors++; $display("FAIL add_latency: got %0d required %0d", lat, LAT + 1); end
    checks++; if (id !== 2'd0) begin errors++; $display("FAIL add_id: got %0d required 0", id); end
    checks++; if (d !== 32'h40400000) begin errors++; $display("FAIL add_data: got %h required 40400000", d); end
  endtask

  task automatic test_sub_nan();
    logic [N-1:0] rdy; logic [31:0] l, r, d; logic [IDW-1:0] id; int lat;
    single_op(2, 32'h40400000, 32'h3F800000, 1'b1, rdy, l, r, lat, id, d);
    checks++; if (r !== 32'hBF800000) begin errors++; $display("FAIL sub_rhs: got %h required bf800000", r); end
    checks++; if (id !== 2'd2) begin errors++; $display("FAIL sub_id: got %0d required 2", id); end
    checks++; if (d !== 32'h40000000) begin errors++; $display("FAIL sub_data: got %h required 40000000", d); end
    single_op(1, 32'h7FA00000, 32'h3F800000, 1'b0, rdy, l, r, lat, id, d);
    checks++; if (l !== 32'h7FA00000) begin errors++; $display("FAIL nan_passthru: got %h required 7fa00000", l); end
    checks++; if (!is_nan(d) || id !== 2'd1) begin errors++; $display("FAIL nan_result: got id=%0d data=%h required id=1 NaN", id, d); end
  endtask

  task automatic test_round_robin();
    int g;
    do_reset();
    rand_operands();
    req_valid = '1; res_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      g = onehot_idx(req_ready);
      checks++;
      if (g != k % N) begin errors++; $display("FAIL rr_order step %0d: grant=%0d required %0d", k, g, k % N); end
      tick();
    end
    req_valid = '0;
    repeat (8) tick();
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    rand_operands();
    req_valid = '1; res_ready = 1'b0;
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (req_ready != '0) n++;
      tick();
    end
    checks++; if (n != DEPTH) begin errors++; $display("FAIL bp_issues: got %0d required %0d", n, DEPTH); end
    @(negedge clk);
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL bp_stall: req_ready=%b required 0", req_ready); end
    tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (req_ready != '0) n++;
      tick();
    end
    checks++; if (n != 1) begin errors++; $display("FAIL bp_one_more: got %0d required 1", n); end
  endtask

  // Starts from a full FIFO: popping every cycle frees a credit that is reused
  // in the same cycle as the next pop, so issue continues at one per cycle.
  task automatic test_same_cycle();
    int n;
    res_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_ready != '0) n++;
      checks++;
      if (res_valid !== 1'b1) begin errors++; $display("FAIL steady_valid step %0d: got %b required 1", k, res_valid); end
      tick();
    end
    checks++; if (n != 9) begin errors++; $display("FAIL steady_issues: got %0d required 9", n); end
    req_valid = '0;
    repeat (10) tick();
    @(negedge clk);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL steady_drain: res_valid=%b required 0", res_valid); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      tick();
      rand_operands();
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      res_ready = ($urandom_range(0, 3) != 0);
    end
    tick();
    req_valid = '0; res_ready = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    checks++;
    if (q_id.size() != 0 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL random_drain: %0d results missing, res_valid=%b required 0 and 0", q_id.size(), res_valid);
    end
  endtask

  task automatic test_reset_midflight();
    logic [N-1:0] rdy; logic [31:0] l, r, d; logic [IDW-1:0] id; int lat;
    tick();
    rand_operands();
    req_valid = '1; res_ready = 1'b0;
    tick();
    tick();
    req_valid = '0; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0) begin errors++; $display("FAIL stale_result step %0d: res_valid=%b required 0", k, res_valid); end
    end
    single_op(3, i2f(5), i2f(7), 1'b0, rdy, l, r, lat, id, d);
    checks++;
    if (rdy !== 4'b1000 || lat != LAT + 1 || id !== 2'd3 || d !== i2f(12)) begin
      errors++;
      $display("FAIL post_reset_op: rdy=%b lat=%0d id=%0d data=%h required 1000 %0d 3 %h",
               rdy, lat, id, d, LAT + 1, i2f(12));
    end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_sub_nan();
    test_round_robin();
    test_backpressure();
    test_same_cycle();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
